// File: rtl/lobster_mem_pkg.sv
// Package: lobster_mem_pkg
// Purpose: shared types and constants for the lobster memory responder and
//          the CPU data bus (state encoding, word geometry, bus mode codes).
// Contents:
//   memrsp_state_t  - responder FSM states (IDLE, WAIT, DONE)
//   WORD_W          - data word width in bits (64)
//   WORD_BYTES_LOG2 - log2 of bytes per word (3)
//   DBUS_READ/WRITE - value of the bus 'we' line for each command kind
package lobster_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memrsp_state_t;

    localparam int WORD_W          = 64;
    localparam int WORD_BYTES_LOG2 = 3;

    localparam logic DBUS_READ  = 1'b0;
    localparam logic DBUS_WRITE = 1'b1;

endpackage

// File: rtl/lobster_sram_array.sv
// Module: lobster_sram_array
// Purpose: 1R1W synchronous word array, 2**DEPTH_LOG2 words of WORD_W bits.
//          Read data is registered every clock from raddr. When a write and a
//          read hit the same word on the same edge, the new data is returned.
//          No reset: contents survive a responder reset.
// Ports:
//   clk   in   1           clock
//   we    in   1           write enable
//   waddr in   DEPTH_LOG2  write word index
//   wdata in   WORD_W      write data
//   raddr in   DEPTH_LOG2  read word index
//   rdata out  WORD_W      registered read data
module lobster_sram_array
    import lobster_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        // Write-first bypass so a same-edge read sees the new word.
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lobster_mem_responder.sv
// Module: lobster_mem_responder
// Purpose: memory-side responder for the CPU data bus. Accepts one read or
//          write at a time, completes it LATENCY cycles after accept with a
//          one-cycle rdy pulse. Backed by lobster_sram_array.
// Ports:
//   clk       in   1           clock, posedge
//   rst       in   1           asynchronous active-low reset
//   ce        in   1           command enable
//   we        in   1           1 = write, 0 = read (sampled with ce)
//   addr_in   in   ADDR_WIDTH  read byte address
//   addr_out  in   ADDR_WIDTH  write byte address
//   data_out  in   64          write data
//   data_in   out  64          read data, valid with rdy, held until next read
//   rdy       out  1           response strobe, one cycle
//   err       out  1           out-of-range flag with rdy (LOBSTER_MEMRSP_ERR_EN only)
//   dbg_state out  2           current FSM state, for observation
// Configuration: define LOBSTER_MEMRSP_ERR_EN to add the err output.
// Handshake: a request is taken on any edge where the FSM is IDLE and ce=1;
//   inputs are ignored until rdy has pulsed and the FSM is IDLE again.
module lobster_mem_responder
    import lobster_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 36,
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [WORD_W-1:0]     data_out,
    output logic [WORD_W-1:0]     data_in,
    output logic                  rdy,
`ifdef LOBSTER_MEMRSP_ERR_EN
    output logic                  err,
`endif
    output memrsp_state_t         dbg_state
);

    localparam int         HI_LSB   = WORD_BYTES_LOG2 + DEPTH_LOG2;
    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    memrsp_state_t         state;
    logic [3:0]            cnt;
    logic                  we_q;
    logic                  oor_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [WORD_W-1:0]     data_hold;

    logic                  accept;
    logic                  go_done;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  cur_we;
    logic                  cur_oor;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic [WORD_W-1:0]     cur_wdata;
    logic                  arr_we;
    logic [WORD_W-1:0]     rdata;
    logic                  unused_low_bits;

    // In IDLE the request comes straight from the bus, so a LATENCY=1
    // request can touch the array on its accept edge; afterwards the
    // captured copy is used.
    always_comb begin
        accept    = (state == IDLE) && ce;
        req_addr  = (we == DBUS_WRITE) ? addr_out : addr_in;
        cur_we    = we_q;
        cur_oor   = oor_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        if (state == IDLE) begin
            cur_we    = we;
            cur_oor   = (req_addr[ADDR_WIDTH-1:HI_LSB] != '0);
            cur_idx   = req_addr[WORD_BYTES_LOG2 +: DEPTH_LOG2];
            cur_wdata = data_out;
        end
        // go_done is true on exactly the edge that enters DONE.
        go_done = (accept && (LATENCY == 1)) ||
                  ((state == WAIT) && (cnt == CNT_LAST));
        arr_we  = go_done && (cur_we == DBUS_WRITE) && !cur_oor;
    end

    assign unused_low_bits = ^req_addr[WORD_BYTES_LOG2-1:0];

    lobster_sram_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (cur_idx),
        .wdata (cur_wdata),
        .raddr (cur_idx),
        .rdata (rdata)
    );

    // Array read lands in rdata on the edge entering DONE, so during DONE
    // the response is taken from the array; otherwise the last read is held.
    always_comb begin
        data_in = data_hold;
        if ((state == DONE) && (we_q == DBUS_READ)) begin
            data_in = oor_q ? '0 : rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            data_hold <= '0;
            rdy       <= 1'b0;
        end else begin
            rdy <= go_done;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= cur_we;
                        oor_q   <= cur_oor;
                        idx_q   <= cur_idx;
                        wdata_q <= cur_wdata;
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    data_hold <= data_in;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOBSTER_MEMRSP_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= go_done && cur_oor;
        end
    end
`endif

    assign dbg_state = state;

endmodule

// File: tb/tb_lobster_mem_responder.sv
// Bench for lobster_mem_responder. Two instances share one set of bus inputs:
//   dut_a: LATENCY=2, DEPTH_LOG2=13 (64 KiB, so 0xF800 lies inside the array)
//   dut_b: LATENCY=1, default depth
// Each scenario checks only the instance it targets.
module tb_lobster_mem_responder;
    import lobster_mem_pkg::*;

    localparam int AW = 36;

    logic          clk;
    logic          rst;
    logic          ce;
    logic          we;
    logic [AW-1:0] addr_in;
    logic [AW-1:0] addr_out;
    logic [63:0]   data_out;

    logic [63:0]   data_in_a, data_in_b;
    logic          rdy_a, rdy_b;
    logic          err_a, err_b;
    memrsp_state_t dbg_a, dbg_b;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    lobster_mem_responder #(.ADDR_WIDTH(AW), .DEPTH_LOG2(13), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .we(we),
        .addr_in(addr_in), .addr_out(addr_out), .data_out(data_out),
        .data_in(data_in_a), .rdy(rdy_a),
`ifdef LOBSTER_MEMRSP_ERR_EN
        .err(err_a),
`endif
        .dbg_state(dbg_a)
    );

    lobster_mem_responder #(.ADDR_WIDTH(AW), .DEPTH_LOG2(12), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .we(we),
        .addr_in(addr_in), .addr_out(addr_out), .data_out(data_out),
        .data_in(data_in_b), .rdy(rdy_b),
`ifdef LOBSTER_MEMRSP_ERR_EN
        .err(err_b),
`endif
        .dbg_state(dbg_b)
    );

`ifndef LOBSTER_MEMRSP_ERR_EN
    assign err_a = 1'b0;
    assign err_b = 1'b0;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request to the selected instance and wait (bounded) for rdy.
    task automatic issue(input bit sel_b, input logic w, input logic [AW-1:0] a,
                         input logic [63:0] d, input int exp_lat, input string tag,
                         output logic [63:0] rdat, output logic rerr);
        int lat;
        ce       = 1'b1;
        we       = w;
        addr_out = w ? a : '0;
        addr_in  = w ? '0 : a;
        data_out = d;
        @(posedge clk); #1;
        ce  = 1'b0;
        we  = ~w;
        lat = 0;
        rdat = '0;
        rerr = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (sel_b ? rdy_b : rdy_a) begin
                lat  = i;
                rdat = sel_b ? data_in_b : data_in_a;
                rerr = sel_b ? err_b : err_a;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(sel_b ? rdy_b : rdy_a), 64'(0));
    endtask

    initial begin
        logic [63:0] rd;
        logic        e;
        logic [63:0] last_rd;

        rst = 1'b0; ce = 1'b0; we = 1'b0;
        addr_in = '0; addr_out = '0; data_out = '0;

        // Test 1: reset values, then idle bus
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy_a", 64'(rdy_a), 64'(0));
        check("rst_data_a", data_in_a, 64'h0);
        check("rst_state_a", 64'(dbg_a), 64'(IDLE));
        check("rst_rdy_b", 64'(rdy_b), 64'(0));
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle_rdy_%0d", i), 64'(rdy_a | rdy_b), 64'(0));
            check($sformatf("idle_data_%0d", i), data_in_a | data_in_b, 64'h0);
        end

        // Test 3: ce held high, LATENCY=1, alternating write/read
        last_rd  = 64'h0;
        ce       = 1'b1;
        we       = 1'b1;
        addr_out = 36'h10;
        addr_in  = '0;
        data_out = 64'h0123_4567_89AB_CDEF;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            check($sformatf("t3_rdy_%0d", j), 64'(rdy_b), 64'((j % 2) == 0));
            if (j == 2 || j == 6) begin
                last_rd = exp_q.pop_front();
                check($sformatf("t3_rd_%0d", j), data_in_b, last_rd);
            end else begin
                check($sformatf("t3_hold_%0d", j), data_in_b, last_rd);
            end
            case (j)
                0: begin
                    we = 1'b0; addr_in = 36'h10; addr_out = '0;
                    exp_q.push_back(64'h0123_4567_89AB_CDEF);
                end
                2: begin
                    we = 1'b1; addr_out = 36'h18; addr_in = '0;
                    data_out = 64'hFEDC_BA98_7654_3210;
                end
                4: begin
                    we = 1'b0; addr_in = 36'h18; addr_out = '0;
                    exp_q.push_back(64'hFEDC_BA98_7654_3210);
                end
                6: ce = 1'b0;
                default: ;
            endcase
        end
        repeat (4) @(posedge clk);
        #1;

        // Test 2: write then read 0xF800, LATENCY=2
        issue(1'b0, 1'b1, 36'hF800, 64'hDEAD_BEEF_0123_4567, 2, "t2_wr", rd, e);
        issue(1'b0, 1'b0, 36'hF800, 64'h0, 2, "t2_rd", rd, e);
        check("t2_data", rd, 64'hDEAD_BEEF_0123_4567);

        // Test 4: low address bits ignored
        issue(1'b0, 1'b0, 36'hF803, 64'h0, 2, "t4_rd", rd, e);
        check("t4_data", rd, 64'hDEAD_BEEF_0123_4567);

        // Test 5: out-of-range at 1<<(3+13)
        issue(1'b0, 1'b1, 36'h0, 64'h1111_2222_3333_4444, 2, "t5_w0", rd, e);
        check("t5_w0_hold", rd, 64'hDEAD_BEEF_0123_4567);
        issue(1'b0, 1'b1, 36'h1_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2, "t5_woor", rd, e);
`ifdef LOBSTER_MEMRSP_ERR_EN
        check("t5_woor_err", 64'(e), 64'(1));
`endif
        issue(1'b0, 1'b0, 36'h1_0000, 64'h0, 2, "t5_roor", rd, e);
        check("t5_roor_data", rd, 64'h0);
`ifdef LOBSTER_MEMRSP_ERR_EN
        check("t5_roor_err", 64'(e), 64'(1));
`endif
        issue(1'b0, 1'b0, 36'h0, 64'h0, 2, "t5_r0", rd, e);
        check("t5_r0_data", rd, 64'h1111_2222_3333_4444);
`ifdef LOBSTER_MEMRSP_ERR_EN
        check("t5_r0_err", 64'(e), 64'(0));
`endif

        // Test 6: reset during WAIT drops the pending write
        issue(1'b0, 1'b1, 36'h20, 64'hA5A5_0000_FFFF_1234, 2, "t6_w0", rd, e);
        ce = 1'b1; we = 1'b1; addr_out = 36'h20; addr_in = '0;
        data_out = 64'h0BAD_0BAD_0BAD_0BAD;
        @(posedge clk); #1;
        ce = 1'b0;
        check("t6_wait", 64'(dbg_a), 64'(WAIT));
        rst = 1'b0;
        #1;
        check("t6_rst_state", 64'(dbg_a), 64'(IDLE));
        check("t6_rst_rdy", 64'(rdy_a), 64'(0));
        check("t6_rst_data", data_in_a, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("t6_no_rdy_%0d", i), 64'(rdy_a), 64'(0));
        end
        issue(1'b0, 1'b0, 36'h20, 64'h0, 2, "t6_rd", rd, e);
        check("t6_data", rd, 64'hA5A5_0000_FFFF_1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "time limit");
    end

endmodule
